// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// csa_pkg : shared constants and FSM encoding for the CSA output serializer
// Revision: 1.0
// ============================================================================
package csa_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int CSA_OUT_WORDS  = 7;

  // Word offsets of the fields inside one result record
  localparam int WORD_BLOCK       = 0;
  localparam int WORD_IN          = 1;
  localparam int WORD_TIMES       = 3;
  localparam int WORD_TIMES_START = 4;
  localparam int WORD_OUT         = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_SEND    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    FETCH   = ST_FETCH,
    CAPTURE = ST_CAPTURE,
    SEND    = ST_SEND
  } state_e;

endpackage : csa_pkg
`default_nettype wire

// File: rtl/csa_out_serializer.sv
`default_nettype none
// ============================================================================
// csa_out_serializer : pops one record from the CSA output FIFO and streams it
//                      as indexed valid/ready beats, counting completed records
// Revision: 1.0
// ============================================================================
module csa_out_serializer
  import csa_pkg::*;
#(
  parameter int AXI_DATA_WIDTH           = csa_pkg::AXI_DATA_WIDTH,
  parameter int WORDS                    = csa_pkg::CSA_OUT_WORDS,
  parameter int CSA_OUT_PARAMETER_LENGTH = AXI_DATA_WIDTH * WORDS,
  parameter int INDEX_WIDTH              = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                csa_out_ready,
  output logic                                csa_out_ren,
  input  logic [CSA_OUT_PARAMETER_LENGTH-1:0] csa_out,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [AXI_DATA_WIDTH-1:0]           m_data,
  output logic [INDEX_WIDTH-1:0]              m_index,
  output logic                                m_last,
  output logic                                busy,
  output logic [31:0]                         record_count
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(WORDS - 1);

  state_e                                state_q, state_d;
  logic [CSA_OUT_PARAMETER_LENGTH-1:0]   record_q, record_d;
  logic [INDEX_WIDTH-1:0]                idx_q, idx_d;
  logic [AXI_DATA_WIDTH-1:0]             data_q, data_d;
  logic                                  valid_q, valid_d;
  logic                                  last_q, last_d;
  logic [31:0]                           count_q, count_d;
  logic                                  ren;
  logic [INDEX_WIDTH-1:0]                idx_inc;

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    record_d = record_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    count_d  = count_q;
    ren      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && csa_out_ready) begin
          ren     = 1'b1;
          state_d = FETCH;
        end
      end

      // FIFO registers the read on this edge; data appears next cycle
      FETCH: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        record_d = csa_out;
        idx_d    = '0;
        data_d   = csa_out[AXI_DATA_WIDTH-1:0];
        valid_d  = 1'b1;
        last_d   = (LAST_IDX == '0);
        state_d  = SEND;
      end

      SEND: begin
        if (valid_q && m_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = '0;
            count_d = count_q + 32'd1;
            state_d = IDLE;
          end else begin
            idx_d  = idx_inc;
            data_d = record_q[idx_inc*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      record_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      record_q <= record_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      count_q  <= count_d;
    end
  end

  // The read strobe is decoded from IDLE, which is also the reset state, so it
  // is masked while reset is held to keep the FIFO from being popped.
  assign csa_out_ren  = ren & rst_n;
  assign m_valid      = valid_q;
  assign m_data       = data_q;
  assign m_index      = idx_q;
  assign m_last       = last_q;
  assign busy         = (state_q != IDLE);
  assign record_count = count_q;

endmodule : csa_out_serializer
`default_nettype wire

// File: tb/tb_csa_out_serializer.sv
`default_nettype none
// ============================================================================
// tb_csa_out_serializer : randomized record stream against a FIFO/beat model
// Revision: 1.0
// ============================================================================
module tb_csa_out_serializer;

  localparam int W   = 32;
  localparam int N   = 7;
  localparam int LEN = W * N;
  localparam int IW  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            csa_out_ready;
  logic            csa_out_ren;
  logic [LEN-1:0]  csa_out = '0;
  logic            m_valid;
  logic            m_ready;
  logic [W-1:0]    m_data;
  logic [IW-1:0]   m_index;
  logic            m_last;
  logic            busy;
  logic [31:0]     record_count;

  always #5 clk = ~clk;

  csa_out_serializer #(
    .AXI_DATA_WIDTH           (W),
    .WORDS                    (N),
    .CSA_OUT_PARAMETER_LENGTH (LEN),
    .INDEX_WIDTH              (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .csa_out_ready (csa_out_ready),
    .csa_out_ren   (csa_out_ren),
    .csa_out       (csa_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_index       (m_index),
    .m_last        (m_last),
    .busy          (busy),
    .record_count  (record_count)
  );

  // Output FIFO model: registered read, data valid the cycle after the strobe
  logic [LEN-1:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int ren_total = 0;
  int ren_busy_bad = 0;
  int ren_empty_bad = 0;
  int ren_cycles[$];

  assign csa_out_ready = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (csa_out_ren === 1'b1) begin
      ren_total++;
      ren_cycles.push_back(cyc);
      if (busy) ren_busy_bad++;
      if (wr_ptr == rd_ptr) ren_empty_bad++;
      else begin
        csa_out <= fifo_mem[rd_ptr % 16];
        rd_ptr  <= rd_ptr + 1;
      end
    end
    cyc++;
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_count = '0;

  logic [31:0] got_data[$];
  logic [2:0]  got_idx[$];
  logic        got_last[$];
  int          got_cyc[$];
  int          stall_bad;
  bit          timed_out;

  task automatic push_record(input logic [LEN-1:0] r);
    fifo_mem[wr_ptr % 16] = r;
    wr_ptr++;
    for (int i = 0; i < N; i++) exp_q.push_back(r[i*W +: W]);
  endtask

  function automatic logic [LEN-1:0] rand_record();
    logic [LEN-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  // Drive m_ready and gather accepted beats; a beat counts when m_valid and
  // m_ready are both high going into the next rising edge.
  task automatic collect(input int n, input bit bp, input int drop_at, input int budget);
    logic [31:0] pd;
    logic [2:0]  pi;
    logic        pl;
    bit          pstall;
    int          k;
    got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    stall_bad = 0; timed_out = 0; pstall = 0; k = 0;
    pd = '0; pi = '0; pl = 1'b0;
    while (got_data.size() < n) begin
      @(negedge clk);
      if (k >= budget) begin
        timed_out = 1;
        break;
      end
      m_ready = bp ? (((k % 4) == 0) || ((k % 4) == 3)) : 1'b1;
      if (pstall && (m_valid !== 1'b1 || m_data !== pd || m_index !== pi || m_last !== pl))
        stall_bad++;
      pstall = (m_valid === 1'b1) && !m_ready;
      pd = m_data; pi = m_index; pl = m_last;
      if (m_valid === 1'b1 && m_ready) begin
        got_data.push_back(m_data);
        got_idx.push_back(m_index);
        got_last.push_back(m_last);
        got_cyc.push_back(cyc);
        if (got_data.size() == drop_at + 1) enable = 1'b0;
      end
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    checks++; if (m_index !== '0) begin failures++; $display("FAIL reset_m_index got=%0d exp=0", m_index); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (record_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%h exp=0", record_count); end
    checks++; if (csa_out_ren !== 1'b0) begin failures++; $display("FAIL reset_ren got=%b exp=0", csa_out_ren); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [LEN-1:0] r;
    logic [31:0]    e;
    int             r0;
    for (int i = 0; i < N; i++) r[i*W +: W] = 32'(i);
    r0 = ren_total;
    push_record(r);
    enable = 1'b1;
    collect(N, 1'b0, -1, 60);
    @(negedge clk);
    model_count = model_count + 32'd1;
    checks++; if (timed_out) begin failures++; $display("FAIL single_timeout got=%0d beats exp=%0d", got_data.size(), N); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    checks++; if (ren_total - r0 != 1) begin failures++; $display("FAIL single_ren_pulses got=%0d exp=1", ren_total - r0); end
    if (got_data.size() > 0 && ren_cycles.size() > 0) begin
      checks++;
      if (got_cyc[0] - ren_cycles[ren_cycles.size()-1] != 3) begin
        failures++; $display("FAIL single_latency got=%0d exp=3", got_cyc[0] - ren_cycles[ren_cycles.size()-1]);
      end
    end
    for (int i = 0; i < got_data.size(); i++) begin
      e = exp_q.pop_front();
      checks++; if (got_data[i] !== e) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", i, got_data[i], e); end
      checks++; if (got_idx[i] !== 3'(i)) begin failures++; $display("FAIL single_index[%0d] got=%0d exp=%0d", i, got_idx[i], i); end
      checks++; if (got_last[i] !== (i == N-1)) begin failures++; $display("FAIL single_last[%0d] got=%b exp=%b", i, got_last[i], i == N-1); end
      checks++; if (got_cyc[i] - got_cyc[0] != i) begin failures++; $display("FAIL single_spacing[%0d] got=%0d exp=%0d", i, got_cyc[i] - got_cyc[0], i); end
    end
    checks++; if (record_count !== model_count) begin failures++; $display("FAIL single_count got=%h exp=%h", record_count, model_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    push_record(rand_record());
    enable = 1'b1;
    collect(N, 1'b1, -1, 200);
    m_ready = 1'b1;
    @(negedge clk);
    model_count = model_count + 32'd1;
    checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=%0d beats exp=%0d", got_data.size(), N); end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d changes exp=0", stall_bad); end
    for (int i = 0; i < got_data.size(); i++) begin
      e = exp_q.pop_front();
      checks++; if (got_data[i] !== e) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_data[i], e); end
      checks++; if (got_idx[i] !== 3'(i)) begin failures++; $display("FAIL bp_index[%0d] got=%0d exp=%0d", i, got_idx[i], i); end
    end
    checks++; if (record_count !== model_count) begin failures++; $display("FAIL bp_count got=%h exp=%h", record_count, model_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int          r0;
    int          n0;
    r0 = ren_total;
    n0 = ren_cycles.size();
    for (int k = 0; k < 3; k++) push_record(rand_record());
    enable = 1'b1;
    collect(3*N, 1'b0, -1, 200);
    @(negedge clk);
    model_count = model_count + 32'd3;
    checks++; if (timed_out) begin failures++; $display("FAIL b2b_timeout got=%0d beats exp=%0d", got_data.size(), 3*N); end
    checks++; if (ren_total - r0 != 3) begin failures++; $display("FAIL b2b_ren_pulses got=%0d exp=3", ren_total - r0); end
    for (int k = 1; k < 3; k++) begin
      if (ren_cycles.size() > n0 + k) begin
        checks++;
        if (ren_cycles[n0+k] - ren_cycles[n0+k-1] != N + 3) begin
          failures++; $display("FAIL b2b_ren_gap[%0d] got=%0d exp=%0d", k, ren_cycles[n0+k] - ren_cycles[n0+k-1], N + 3);
        end
      end
    end
    checks++; if (ren_busy_bad != 0) begin failures++; $display("FAIL b2b_ren_while_busy got=%0d exp=0", ren_busy_bad); end
    for (int i = 0; i < got_data.size(); i++) begin
      e = exp_q.pop_front();
      checks++; if (got_data[i] !== e) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_data[i], e); end
      checks++; if (got_idx[i] !== 3'(i % N)) begin failures++; $display("FAIL b2b_index[%0d] got=%0d exp=%0d", i, got_idx[i], i % N); end
    end
    checks++; if (record_count !== model_count) begin failures++; $display("FAIL b2b_count got=%h exp=%h", record_count, model_count); end
  endtask

  task automatic test_enable();
    logic [31:0] e;
    int          r0;
    int          vbad;
    enable = 1'b0;
    r0 = ren_total;
    vbad = 0;
    push_record(rand_record());
    repeat (20) begin
      @(negedge clk);
      if (m_valid !== 1'b0) vbad++;
    end
    checks++; if (ren_total != r0) begin failures++; $display("FAIL en_off_ren got=%0d exp=0", ren_total - r0); end
    checks++; if (vbad != 0) begin failures++; $display("FAIL en_off_valid got=%0d exp=0", vbad); end
    push_record(rand_record());
    enable = 1'b1;
    collect(N, 1'b0, 2, 100);
    repeat (15) @(negedge clk);
    model_count = model_count + 32'd1;
    checks++; if (timed_out) begin failures++; $display("FAIL en_drop_timeout got=%0d beats exp=%0d", got_data.size(), N); end
    checks++; if (ren_total - r0 != 1) begin failures++; $display("FAIL en_drop_ren got=%0d exp=1", ren_total - r0); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL en_drop_valid got=%b exp=0", m_valid); end
    for (int i = 0; i < got_data.size(); i++) begin
      e = exp_q.pop_front();
      checks++; if (got_data[i] !== e) begin failures++; $display("FAIL en_drop_data[%0d] got=%h exp=%h", i, got_data[i], e); end
    end
    checks++; if (record_count !== model_count) begin failures++; $display("FAIL en_drop_count got=%h exp=%h", record_count, model_count); end
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    int r0;
    int act;
    push_record(rand_record());
    enable = 1'b1;
    collect(5, 1'b0, -1, 100);
    checks++; if (timed_out) begin failures++; $display("FAIL rst_timeout got=%0d beats exp=5", got_data.size()); end
    wr_ptr = rd_ptr;
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    model_count = '0;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%b exp=0", m_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    checks++; if (record_count !== 32'd0) begin failures++; $display("FAIL rst_async_count got=%h exp=0", record_count); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = ren_total;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) act++;
    end
    checks++; if (act != 0) begin failures++; $display("FAIL rst_post_activity got=%0d exp=0", act); end
    checks++; if (ren_total != r0) begin failures++; $display("FAIL rst_post_ren got=%0d exp=0", ren_total - r0); end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    model_count = 32'hFFFF_FFFF;
    checks++; if (record_count !== model_count) begin failures++; $display("FAIL wrap_preload got=%h exp=%h", record_count, model_count); end
    push_record(rand_record());
    enable = 1'b1;
    collect(N, 1'b0, -1, 60);
    @(negedge clk);
    model_count = model_count + 32'd1;
    checks++; if (timed_out) begin failures++; $display("FAIL wrap_timeout got=%0d beats exp=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size(); i++) begin
      e = exp_q.pop_front();
      checks++; if (got_data[i] !== e) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got_data[i], e); end
    end
    checks++; if (record_count !== model_count) begin failures++; $display("FAIL wrap_count got=%h exp=%h", record_count, model_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_wrap();
    checks++; if (ren_empty_bad != 0) begin failures++; $display("FAIL fifo_underflow got=%0d exp=0", ren_empty_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_csa_out_serializer
`default_nettype wire

// File: doc/csa_out_serializer.md
Name: csa_out_serializer

Overview:
- Downstream consumer of the CSA calculation output FIFO.
- Pops one CSA_OUT_PARAMETER_LENGTH-bit result record when the FIFO reports data ready.
- Registers the record and streams it as AXI_DATA_WIDTH-bit beats over a valid/ready interface, tagging each beat with its index and marking the final beat with m_last.
- Feeds the AXI-side readback / DMA logic and keeps a running count of completed records.

Parameters:
- AXI_DATA_WIDTH, 32, beat width in bits.
- WORDS, 7, beats per record.
- CSA_OUT_PARAMETER_LENGTH, AXI_DATA_WIDTH * WORDS, record width in bits.
- INDEX_WIDTH, 3, width of m_index; must satisfy 2^INDEX_WIDTH >= WORDS.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  permits new record fetches.
- csa_out_ready  in  1  output FIFO holds at least one record.
- csa_out_ren  out  1  one-cycle FIFO read strobe.
- csa_out  in  CSA_OUT_PARAMETER_LENGTH  FIFO read data; valid the cycle after csa_out_ren.
- m_valid  out  1  beat valid.
- m_ready  in  1  sink accepts beat.
- m_data  out  AXI_DATA_WIDTH  beat payload.
- m_index  out  INDEX_WIDTH  beat number, 0..WORDS-1.
- m_last  out  1  high on beat WORDS-1.
- busy  out  1  high in any state other than IDLE.
- record_count  out  32  completed records, modulo 2^32.

Behaviour:
- Reset: asynchronous on rst_n low, all registers cleared.
  - Outputs during reset: csa_out_ren=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, record_count=0, state=IDLE.
  - Asserting reset mid-record discards that record; no beat from it is emitted after reset is released.
- FSM states: IDLE, FETCH, CAPTURE, SEND.
  - IDLE: when enable=1 and csa_out_ready=1, assert csa_out_ren for exactly one cycle and go to FETCH. Otherwise stay in IDLE.
  - FETCH: csa_out_ren=0; go to CAPTURE.
  - CAPTURE: latch csa_out into the record register, set beat index=0, go to SEND.
  - SEND: m_valid=1, m_data = record[(idx+1)*AXI_DATA_WIDTH-1 : idx*AXI_DATA_WIDTH], m_index=idx, m_last=(idx==WORDS-1).
    - On m_valid & m_ready with idx<WORDS-1: idx increments.
    - On m_valid & m_ready with idx==WORDS-1: record_count increments and state returns to IDLE.
- FIFO read latency: data is sampled exactly two edges after the csa_out_ren edge, matching the FIFO's registered read.
- Handshake rules:
  - m_data, m_index and m_last are registered and stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_ready is ignored while m_valid=0.
- Record order: beat 0 = bits [31:0] (block number); beats 3..4 = times, times_start; beats 5..6 = calc result (low word first).
- Latency: first beat has m_valid=1 three cycles after the csa_out_ren cycle. Minimum record period is WORDS+3 cycles; there is no prefetch.
- enable: sampled only in IDLE. Deasserting it mid-record does not abort; the current record completes.
- csa_out_ren is never asserted when csa_out_ready=0 and never asserted outside IDLE. Therefore at most one record is in flight and the FIFO cannot underflow.
- record_count wraps from 0xFFFFFFFF to 0 without flagging.
- m_ready held low indefinitely: the FSM stalls in SEND and no further FIFO reads occur.

Decomposition:
- Shared package (csa_pkg):
  - AXI_DATA_WIDTH
  - CSA_OUT words constant (7)
  - word-offset constants: BLOCK=0, IN=1, TIMES=3, TIMES_START=4, OUT=5
  - FSM state encoding (2-bit localparams)
- No sub-module is needed. The beat mux is an indexed part-select of the record register, kept inline.

Test Plan:
1. Reset, then one record with words 0x00000000..0x00000006 preloaded, enable=1, m_ready=1 constantly.
   - Exactly one csa_out_ren pulse.
   - Beats 0..6 on consecutive cycles with m_index 0..6.
   - m_last only on beat 6; record_count=1; busy falls the cycle after beat 6.
2. Backpressure: same record, m_ready toggling 1,0,0,1 repeating.
   - No beat is duplicated or skipped.
   - m_data is stable across every stall cycle; all 7 beats are received in order.
3. Three records queued with m_ready=1.
   - csa_out_ren pulses spaced exactly 10 cycles apart; record_count=3.
   - No csa_out_ren while busy=1.
4. enable=0 with csa_out_ready=1 for 20 cycles: no csa_out_ren, m_valid=0. Then drop enable to 0 during beat 2 of a record: beats 3..6 still emitted, and no next fetch occurs.
5. Assert rst_n=0 asynchronously (between clock edges) during beat 4.
   - m_valid, busy and record_count are 0 immediately.
   - After release with csa_out_ready=0, no output activity.
6. Preload record_count to 0xFFFFFFFF via a forced value, then send one record: record_count=0x00000000.
